// File: rtl/c3_result_writeback.sv
// C3 result writeback: buffers C3 result beats and drains them in order to the scalar and
// vector register-file write ports. Optional `C3_WB_PERF_EN adds retire/stall perf counters.
module c3_result_writeback #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned VDATA_W = 128,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned VRD_W   = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_v,
    input  logic [RD_W-1:0]    in_rd,
    input  logic [VRD_W-1:0]   in_vrd1,
    input  logic [VRD_W-1:0]   in_vrd2,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [VDATA_W-1:0] in_vdata1,
    input  logic [VDATA_W-1:0] in_vdata2,
    output logic               stall,
    output logic               overflow,
    output logic               wb_x_we,
    output logic [RD_W-1:0]    wb_x_addr,
    output logic [DATA_W-1:0]  wb_x_data,
    input  logic               wb_x_ready,
    output logic               wb_v_we,
    output logic [VRD_W-1:0]   wb_v_addr,
    output logic [VDATA_W-1:0] wb_v_data,
    input  logic               wb_v_ready
`ifdef C3_WB_PERF_EN
    ,
    output logic [15:0]        perf_retired,
    output logic [15:0]        perf_stall_cyc
`endif
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_HIWM = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    typedef enum logic [1:0] {StIdle, StXw, StV1w, StV2w} state_e;
    typedef enum logic [1:0] {SrcHead, SrcNext, SrcIn} src_e;

    // need flags: bit2 = scalar, bit1 = vector 1, bit0 = vector 2
    logic [RD_W-1:0]    r_rd     [DEPTH];
    logic [VRD_W-1:0]   r_vrd1   [DEPTH];
    logic [VRD_W-1:0]   r_vrd2   [DEPTH];
    logic [DATA_W-1:0]  r_data   [DEPTH];
    logic [VDATA_W-1:0] r_vdata1 [DEPTH];
    logic [VDATA_W-1:0] r_vdata2 [DEPTH];
    logic [2:0]         r_need   [DEPTH];

    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    state_e             r_state;
    logic               r_x_we, r_v_we;
    logic [RD_W-1:0]    r_x_addr;
    logic [DATA_W-1:0]  r_x_data;
    logic [VRD_W-1:0]   r_v_addr;
    logic [VDATA_W-1:0] r_v_data;

    logic [PTR_W-1:0]   w_nxt_ptr;
    logic [2:0]         w_head_need, w_in_need;
    logic               w_pop, w_push;
    state_e             w_state_d;
    src_e               w_src;
    logic [RD_W-1:0]    w_sel_rd;
    logic [VRD_W-1:0]   w_sel_vrd1, w_sel_vrd2;
    logic [DATA_W-1:0]  w_sel_data;
    logic [VDATA_W-1:0] w_sel_vdata1, w_sel_vdata2;

    function automatic state_e first_phase(input logic [2:0] need);
        if (need[2]) return StXw;
        if (need[1]) return StV1w;
        if (need[0]) return StV2w;
        return StIdle;
    endfunction

    assign w_nxt_ptr   = r_rd_ptr + PTR_W'(1);
    assign w_head_need = r_need[r_rd_ptr];
    assign w_in_need   = {in_rd != '0, in_vrd1 != '0, in_vrd2 != '0};
    assign w_push      = in_v && ((r_count != CNT_FULL) || w_pop);
    assign stall       = (r_count >= CNT_HIWM);

    always_comb begin
        w_pop     = 1'b0;
        w_state_d = r_state;
        w_src     = SrcHead;
        unique case (r_state)
            StIdle: begin
                if (r_count == '0) begin
                    // Empty FIFO: an incoming beat goes straight into its first phase.
                    if (in_v) begin
                        w_state_d = first_phase(w_in_need);
                        w_src     = SrcIn;
                    end
                end else if (w_head_need == 3'b000) begin
                    w_pop = 1'b1;
                end else begin
                    w_state_d = first_phase(w_head_need);
                end
            end
            StXw: begin
                if (r_x_we && wb_x_ready) begin
                    if (w_head_need[1])      w_state_d = StV1w;
                    else if (w_head_need[0]) w_state_d = StV2w;
                    else                     w_pop = 1'b1;
                end
            end
            StV1w: begin
                if (r_v_we && wb_v_ready) begin
                    if (w_head_need[0]) w_state_d = StV2w;
                    else                w_pop = 1'b1;
                end
            end
            StV2w: begin
                if (r_v_we && wb_v_ready) w_pop = 1'b1;
            end
        endcase
        if (w_pop) begin
            if (r_count >= CNT_TWO) begin
                w_state_d = first_phase(r_need[w_nxt_ptr]);
                w_src     = SrcNext;
            end else begin
                w_state_d = StIdle;
            end
        end
    end

    always_comb begin
        w_sel_rd     = r_rd[r_rd_ptr];
        w_sel_vrd1   = r_vrd1[r_rd_ptr];
        w_sel_vrd2   = r_vrd2[r_rd_ptr];
        w_sel_data   = r_data[r_rd_ptr];
        w_sel_vdata1 = r_vdata1[r_rd_ptr];
        w_sel_vdata2 = r_vdata2[r_rd_ptr];
        case (w_src)
            SrcNext: begin
                w_sel_rd     = r_rd[w_nxt_ptr];
                w_sel_vrd1   = r_vrd1[w_nxt_ptr];
                w_sel_vrd2   = r_vrd2[w_nxt_ptr];
                w_sel_data   = r_data[w_nxt_ptr];
                w_sel_vdata1 = r_vdata1[w_nxt_ptr];
                w_sel_vdata2 = r_vdata2[w_nxt_ptr];
            end
            SrcIn: begin
                w_sel_rd     = in_rd;
                w_sel_vrd1   = in_vrd1;
                w_sel_vrd2   = in_vrd2;
                w_sel_data   = in_data;
                w_sel_vdata1 = in_vdata1;
                w_sel_vdata2 = in_vdata2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wr_ptr]     <= in_rd;
            r_vrd1[r_wr_ptr]   <= in_vrd1;
            r_vrd2[r_wr_ptr]   <= in_vrd2;
            r_data[r_wr_ptr]   <= in_data;
            r_vdata1[r_wr_ptr] <= in_vdata1;
            r_vdata2[r_wr_ptr] <= in_vdata2;
            r_need[r_wr_ptr]   <= w_in_need;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= w_nxt_ptr;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (in_v && !w_push) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_x_we   <= 1'b0;
            r_x_addr <= '0;
            r_x_data <= '0;
            r_v_we   <= 1'b0;
            r_v_addr <= '0;
            r_v_data <= '0;
        end else begin
            r_state  <= w_state_d;
            r_x_we   <= (w_state_d == StXw);
            r_x_addr <= (w_state_d == StXw) ? w_sel_rd : '0;
            r_x_data <= (w_state_d == StXw) ? w_sel_data : '0;
            r_v_we   <= (w_state_d == StV1w) || (w_state_d == StV2w);
            r_v_addr <= (w_state_d == StV1w) ? w_sel_vrd1 :
                        (w_state_d == StV2w) ? w_sel_vrd2 : '0;
            r_v_data <= (w_state_d == StV1w) ? w_sel_vdata1 :
                        (w_state_d == StV2w) ? w_sel_vdata2 : '0;
        end
    end

    assign overflow  = r_overflow;
    assign wb_x_we   = r_x_we;
    assign wb_x_addr = r_x_addr;
    assign wb_x_data = r_x_data;
    assign wb_v_we   = r_v_we;
    assign wb_v_addr = r_v_addr;
    assign wb_v_data = r_v_data;

`ifdef C3_WB_PERF_EN
    logic [15:0] r_perf_retired, r_perf_stall_cyc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_retired   <= '0;
            r_perf_stall_cyc <= '0;
        end else begin
            if (w_pop && (r_perf_retired != 16'hFFFF)) r_perf_retired <= r_perf_retired + 16'd1;
            if (stall && (r_perf_stall_cyc != 16'hFFFF)) begin
                r_perf_stall_cyc <= r_perf_stall_cyc + 16'd1;
            end
        end
    end

    assign perf_retired   = r_perf_retired;
    assign perf_stall_cyc = r_perf_stall_cyc;
`endif

endmodule

// File: tb/tb_c3_result_writeback.sv
// Directed self-checking bench for c3_result_writeback: reset, scalar/vector drains,
// backpressure with overflow, null entries, mid-drain reset and full push/pop wrap.
module tb_c3_result_writeback;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_v;
    logic [4:0]   in_rd;
    logic [2:0]   in_vrd1, in_vrd2;
    logic [31:0]  in_data;
    logic [127:0] in_vdata1, in_vdata2;
    logic         stall, overflow;
    logic         wb_x_we, wb_x_ready;
    logic [4:0]   wb_x_addr;
    logic [31:0]  wb_x_data;
    logic         wb_v_we, wb_v_ready;
    logic [2:0]   wb_v_addr;
    logic [127:0] wb_v_data;
`ifdef C3_WB_PERF_EN
    logic [15:0]  perf_retired, perf_stall_cyc;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] VA = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] VB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;

    always #5 clk = ~clk;

    c3_result_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .in_v       (in_v),
        .in_rd      (in_rd),
        .in_vrd1    (in_vrd1),
        .in_vrd2    (in_vrd2),
        .in_data    (in_data),
        .in_vdata1  (in_vdata1),
        .in_vdata2  (in_vdata2),
        .stall      (stall),
        .overflow   (overflow),
        .wb_x_we    (wb_x_we),
        .wb_x_addr  (wb_x_addr),
        .wb_x_data  (wb_x_data),
        .wb_x_ready (wb_x_ready),
        .wb_v_we    (wb_v_we),
        .wb_v_addr  (wb_v_addr),
        .wb_v_data  (wb_v_data),
        .wb_v_ready (wb_v_ready)
`ifdef C3_WB_PERF_EN
        ,
        .perf_retired   (perf_retired),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [4:0] rd, input logic [2:0] v1,
                        input logic [2:0] v2, input logic [31:0] d, input logic [127:0] vd1,
                        input logic [127:0] vd2);
        in_v = v; in_rd = rd; in_vrd1 = v1; in_vrd2 = v2;
        in_data = d; in_vdata1 = vd1; in_vdata2 = vd2;
    endtask

    task automatic idle_writes(input string tag);
        chk({tag, "_xwe"}, 128'(wb_x_we), 128'(0));
        chk({tag, "_vwe"}, 128'(wb_v_we), 128'(0));
    endtask

    initial begin
        // Reset held 5 cycles with a valid beat on the input.
        reset = 1'b1; wb_x_ready = 1'b1; wb_v_ready = 1'b1;
        beat(1'b1, 5'd9, 3'd1, 3'd2, 32'h99, VA, VB);
        repeat (5) tick();
        chk("rst_stall", 128'(stall), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        idle_writes("rst");
        chk("rst_xaddr", 128'(wb_x_addr), 128'(0));
        reset = 1'b0;
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        tick(); idle_writes("post_rst1");
        tick(); idle_writes("post_rst2");
        chk("post_rst_stall", 128'(stall), 128'(0));

        // Scalar-only beat.
        beat(1'b1, 5'd5, 3'd0, 3'd0, 32'hDEADBEEF, VA, VB);
        tick();
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        chk("sc_xwe", 128'(wb_x_we), 128'(1));
        chk("sc_xaddr", 128'(wb_x_addr), 128'(5));
        chk("sc_xdata", 128'(wb_x_data), 128'(32'hDEADBEEF));
        chk("sc_vwe", 128'(wb_v_we), 128'(0));
        tick(); idle_writes("sc_done");

        // Vector-only beat: v1 then v2 on consecutive cycles.
        beat(1'b1, 5'd0, 3'd2, 3'd3, 32'h1234, VA, VB);
        tick();
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        chk("vo1_vwe", 128'(wb_v_we), 128'(1));
        chk("vo1_addr", 128'(wb_v_addr), 128'(2));
        chk("vo1_data", wb_v_data, VA);
        chk("vo1_xwe", 128'(wb_x_we), 128'(0));
        tick();
        chk("vo2_vwe", 128'(wb_v_we), 128'(1));
        chk("vo2_addr", 128'(wb_v_addr), 128'(3));
        chk("vo2_data", wb_v_data, VB);
        chk("vo2_xwe", 128'(wb_x_we), 128'(0));
        tick(); idle_writes("vo_done");

        // Backpressure: four scalar beats fill the FIFO, a fifth is dropped.
        wb_x_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            beat(1'b1, 5'(i), 3'd0, 3'd0, 32'h100 + 32'(i), VA, VB);
            tick();
            chk($sformatf("bp_stall%0d", i), 128'(stall), 128'(i >= 3));
            chk($sformatf("bp_hold%0d", i), 128'(wb_x_addr), 128'(1));
        end
        beat(1'b1, 5'd5, 3'd0, 3'd0, 32'h105, VA, VB);
        tick();
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        chk("bp_ovf", 128'(overflow), 128'(1));
        chk("bp_xwe_held", 128'(wb_x_we), 128'(1));
        wb_x_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("bp_wr%0d_we", i), 128'(wb_x_we), 128'(1));
            chk($sformatf("bp_wr%0d_addr", i), 128'(wb_x_addr), 128'(i));
            chk($sformatf("bp_wr%0d_data", i), 128'(wb_x_data), 128'(32'h100 + 32'(i)));
            tick();
        end
        idle_writes("bp_done");
        chk("bp_ovf_sticky", 128'(overflow), 128'(1));
        chk("bp_stall_clear", 128'(stall), 128'(0));

        // Null beat followed directly by rd=7.
        beat(1'b1, 5'd0, 3'd0, 3'd0, 32'h55, VA, VB);
        tick(); idle_writes("null_c1");
        beat(1'b1, 5'd7, 3'd0, 3'd0, 32'h77, VA, VB);
        tick(); idle_writes("null_c2");
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        tick();
        chk("null_x7_we", 128'(wb_x_we), 128'(1));
        chk("null_x7_addr", 128'(wb_x_addr), 128'(7));
        chk("null_x7_data", 128'(wb_x_data), 128'(32'h77));
        tick(); idle_writes("null_done");

        // Full beat, vector port stalled, reset while in the V1 phase.
        wb_v_ready = 1'b0;
        beat(1'b1, 5'd4, 3'd5, 3'd6, 32'h44, VA, VB);
        tick();
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        chk("md_xaddr", 128'(wb_x_addr), 128'(4));
        tick();
        chk("md_v1_we", 128'(wb_v_we), 128'(1));
        chk("md_v1_addr", 128'(wb_v_addr), 128'(5));
        chk("md_v1_xwe", 128'(wb_x_we), 128'(0));
        tick();
        chk("md_v1_hold", 128'(wb_v_addr), 128'(5));
        #2 reset = 1'b1;
        #1 chk("md_async_vwe", 128'(wb_v_we), 128'(0));
        chk("md_async_ovf", 128'(overflow), 128'(0));
        tick();
        reset = 1'b0; wb_v_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); idle_writes($sformatf("md_after%0d", i));
        end
        chk("md_stall", 128'(stall), 128'(0));

        // Fill, then push while the head pops on the same edge: accepted, pointers wrap.
        wb_x_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            beat(1'b1, 5'(i + 10), 3'd0, 3'd0, 32'h200 + 32'(i), VA, VB);
            tick();
        end
        wb_x_ready = 1'b1;
        beat(1'b1, 5'd15, 3'd0, 3'd0, 32'h205, VA, VB);
        tick();
        beat(1'b0, 5'd0, 3'd0, 3'd0, 32'h0, '0, '0);
        chk("pp_ovf", 128'(overflow), 128'(0));
        chk("pp_stall", 128'(stall), 128'(1));
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("pp_wr%0d_addr", i), 128'(wb_x_addr), 128'(i + 10));
            chk($sformatf("pp_wr%0d_data", i), 128'(wb_x_data), 128'(32'h200 + 32'(i)));
            tick();
        end
        idle_writes("pp_done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
